// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: tick-driven PWM with a shadowed period/duty config.
// tick_in (slow divided clock) is synchronized and edge-detected, and each
// rising edge advances the PWM counter by one step. New duty/period values
// arrive over a valid/ready handshake and take effect only at a period wrap,
// or on the next clock edge while the block is disabled.
// Optional feature: define PWM_DEADTIME_EN to drive pwm_n_out as the
// complement of pwm_out. Both outputs are then held low for DEADTIME clocks
// after every raw edge.
module pwm_tick_gen #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME    = 4
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] period_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             pwm_out,
    output logic             pwm_n_out,
    output logic             cycle_done
);

    typedef struct packed {
        logic [WIDTH-1:0] duty;
        logic [WIDTH-1:0] top;
    } cfg_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_prev;
    logic                   tick;

    logic [WIDTH-1:0] cnt, cnt_next;
    cfg_t             act_q, act_next, shd_q;
    logic             pending, pending_next;
    logic             accept, wrap, apply;
    logic             raw, raw_next;

    // tick_in is asynchronous: shift it through the synchronizer and keep the previous last-stage value for edge detection
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            tick_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_in};
            tick_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~tick_prev;

    // Next-state for the counter, the active config and the shadow handshake
    always_comb begin
        accept   = cfg_valid && cfg_ready;
        wrap     = enable && tick && (cnt == act_q.top);
        // While disabled there is no period in progress, so a pending config lands immediately
        apply    = pending && (wrap || !enable);

        cnt_next = cnt;
        if (enable && tick)
            cnt_next = wrap ? '0 : cnt + WIDTH'(1);

        act_next = apply ? shd_q : act_q;

        pending_next = pending;
        if (accept)
            pending_next = 1'b1;
        else if (apply)
            pending_next = 1'b0;

        // duty 0 never compares true (constant low); duty > top always does (constant high)
        raw_next = enable && (cnt_next < act_next.duty);
    end

    // Counter, active/shadow config, handshake and raw PWM registers
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            act_q      <= '{duty: '0, top: '1};
            shd_q      <= '{duty: '0, top: '1};
            pending    <= 1'b0;
            cfg_ready  <= 1'b1;
            raw        <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            act_q      <= act_next;
            if (accept)
                shd_q  <= '{duty: duty_in, top: period_in};
            pending    <= pending_next;
            // Tracks !pending exactly, so an accept can never collide with an apply
            cfg_ready  <= !pending_next;
            raw        <= raw_next;
            cycle_done <= wrap;
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam int DTW = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);

    logic [DTW-1:0] dead_cnt;
    logic           pwm_q, pwm_n_q;

    // Dead band: any raw edge forces both sides low and (re)starts the count; the new side asserts when the count expires
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            dead_cnt <= '0;
            pwm_q    <= 1'b0;
            pwm_n_q  <= 1'b0;
        end else if (raw_next != raw) begin
            dead_cnt <= DTW'(DEADTIME);
            pwm_q    <= 1'b0;
            pwm_n_q  <= 1'b0;
        end else if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - DTW'(1);
            pwm_q    <= (dead_cnt == DTW'(1)) && raw_next;
            pwm_n_q  <= (dead_cnt == DTW'(1)) && enable && !raw_next;
        end else begin
            pwm_q    <= raw_next;
            pwm_n_q  <= enable && !raw_next;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_n_out = pwm_n_q;
`else
    logic unused_deadtime;

    assign unused_deadtime = (DEADTIME != 0);
    assign pwm_out         = raw;
    assign pwm_n_out       = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Bench for pwm_tick_gen. The driver issues ticks on tick_in and, for each
// tick, pushes the hand-derived expected output state into a scoreboard
// queue. A separate monitor detects each tick_in rising edge, waits out the
// synchronizer (and dead-band) latency, then pops one entry and compares it.
module tb_pwm_tick_gen;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DT = 4;
`ifdef PWM_DEADTIME_EN
    localparam int EXTRA = DT;
`else
    localparam int EXTRA = 0;
`endif

    logic         clock_in  = 1'b0;
    logic         reset_n   = 1'b0;
    logic         tick_in   = 1'b0;
    logic         enable    = 1'b0;
    logic [W-1:0] duty_in   = '0;
    logic [W-1:0] period_in = '0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready, pwm_out, pwm_n_out, cycle_done;

    pwm_tick_gen #(.WIDTH(W), .SYNC_STAGES(SS), .DEADTIME(DT)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .tick_in   (tick_in),
        .enable    (enable),
        .duty_in   (duty_in),
        .period_in (period_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .pwm_out   (pwm_out),
        .pwm_n_out (pwm_n_out),
        .cycle_done(cycle_done)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic pwm;
        logic pwmn;
        logic cd;
        logic rdy;
        logic chk_rdy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   c     = 0;   // the bench's own idea of the PWM count

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per tick_in rising edge seen at a clock edge
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clock_in);
            if (reset_n && tick_in && !prev) begin
                prev = 1'b1;
                repeat (SS + EXTRA) @(posedge clock_in);
                @(negedge clock_in);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tick: got a tick with no expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("tick_pwm_out", pwm_out, e.pwm);
                    check("tick_pwm_n_out", pwm_n_out, e.pwmn);
                    check("tick_cycle_done", cycle_done, e.cd);
                    if (e.chk_rdy)
                        check("tick_cfg_ready", cfg_ready, e.rdy);
                end
            end else begin
                prev = tick_in;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    // The two sides must never be high together
    always @(negedge clock_in)
        if (pwm_out && pwm_n_out) begin
            n_err++;
            $display("FAIL overlap: pwm_out=1 pwm_n_out=1 required never both at %0t", $time);
        end
`endif

    // One tick: high 4 clocks, low 4 clocks (well above the minimum width)
    task automatic tick_once(input exp_t e);
        sb.push_back(e);
        @(negedge clock_in);
        tick_in = 1'b1;
        repeat (4) @(negedge clock_in);
        tick_in = 1'b0;
        repeat (4) @(negedge clock_in);
    endtask

    // Enabled ticks: count wraps at 'top'; pwm high while count < duty in force
    task automatic run_ticks(input int n, input int duty, input int top,
                             input logic rdy, input logic chk_rdy);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cd      = (c == top);
            c         = e.cd ? 0 : c + 1;
            e.pwm     = (c < duty);
`ifdef PWM_DEADTIME_EN
            e.pwmn    = !e.pwm;
`else
            e.pwmn    = 1'b0;
`endif
            e.rdy     = rdy;
            e.chk_rdy = chk_rdy;
            tick_once(e);
        end
    endtask

    // Ticks while disabled: discarded, outputs low
    task automatic off_ticks(input int n);
        exp_t e;
        e = '{pwm: 1'b0, pwmn: 1'b0, cd: 1'b0, rdy: 1'b1, chk_rdy: 1'b1};
        for (int i = 0; i < n; i++)
            tick_once(e);
    endtask

    task automatic send_cfg(input int d, input int p);
        logic ok;
        ok = 1'b0;
        @(negedge clock_in);
        duty_in   = W'(d);
        period_in = W'(p);
        cfg_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock_in);
        end
        @(negedge clock_in);
        cfg_valid = 1'b0;
        check("cfg_accepted", ok, 1'b1);
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: bench still running at %0t, required finished", $time);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset state
        repeat (3) @(negedge clock_in);
        check("rst_pwm_out", pwm_out, 1'b0);
        check("rst_pwm_n_out", pwm_n_out, 1'b0);
        check("rst_cycle_done", cycle_done, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clock_in);
        check("post_rst_cfg_ready", cfg_ready, 1'b1);

        // Basic PWM: period 9, duty 3, loaded while disabled (applies next edge)
        send_cfg(3, 9);
        @(negedge clock_in);
        check("cfg_ready_after_idle_apply", cfg_ready, 1'b1);
        enable = 1'b1;
        repeat (1 + EXTRA) @(posedge clock_in);
        @(negedge clock_in);
        check("pwm_high_at_cnt0", pwm_out, 1'b1);
        run_ticks(30, 3, 9, 1'b1, 1'b1);

        // Shadow apply: duty 7 arrives at count 5, lands at the wrap
        run_ticks(5, 3, 9, 1'b1, 1'b1);
        send_cfg(7, 9);
        check("cfg_ready_low_pending", cfg_ready, 1'b0);
        run_ticks(4, 3, 9, 1'b0, 1'b1);
        run_ticks(1, 7, 9, 1'b0, 1'b0);
        run_ticks(9, 7, 9, 1'b1, 1'b1);

        // duty 0: constant low
        send_cfg(0, 9);
        run_ticks(1, 0, 9, 1'b0, 1'b0);
        run_ticks(10, 0, 9, 1'b1, 1'b1);

        // duty 12 > period 9: constant high
        send_cfg(12, 9);
        run_ticks(9, 0, 9, 1'b0, 1'b1);
        run_ticks(1, 12, 9, 1'b0, 1'b0);
        run_ticks(10, 12, 9, 1'b1, 1'b1);

        // period 0: wrap (cycle_done) on every tick
        send_cfg(1, 0);
        run_ticks(9, 12, 9, 1'b0, 1'b1);
        run_ticks(1, 1, 9, 1'b0, 1'b0);
        run_ticks(5, 1, 0, 1'b1, 1'b1);

        // Enable drop at count 4 (duty 7 so the output is high when dropped)
        send_cfg(7, 9);
        run_ticks(1, 7, 0, 1'b0, 1'b0);
        run_ticks(4, 7, 9, 1'b1, 1'b1);
        @(negedge clock_in);
        enable = 1'b0;
        @(posedge clock_in);
        @(negedge clock_in);
        check("disable_pwm_out", pwm_out, 1'b0);
        check("disable_pwm_n_out", pwm_n_out, 1'b0);
        off_ticks(5);
        enable = 1'b1;
        repeat (1 + EXTRA) @(posedge clock_in);
        @(negedge clock_in);
        check("reenable_pwm_held_cnt4", pwm_out, 1'b1);
        run_ticks(6, 7, 9, 1'b1, 1'b1);

        // A sub-cycle glitch that no clock edge samples must not count
        @(negedge clock_in);
        #1 tick_in = 1'b1;
        #2 tick_in = 1'b0;
        run_ticks(8, 7, 9, 1'b1, 1'b1);
        run_ticks(2, 7, 9, 1'b1, 1'b1);

        // Reset mid-period with a config pending
        send_cfg(3, 9);
        check("pre_rst_cfg_ready", cfg_ready, 1'b0);
        check("pre_rst_pwm_out", pwm_out, 1'b1);
        @(negedge clock_in);
        reset_n = 1'b0;
        #1;
        check("midrst_pwm_out", pwm_out, 1'b0);
        check("midrst_pwm_n_out", pwm_n_out, 1'b0);
        check("midrst_cycle_done", cycle_done, 1'b0);
        check("midrst_cfg_ready", cfg_ready, 1'b1);
        @(negedge clock_in);
        reset_n = 1'b1;
        c = 0;
        // Pending config was lost: duty 0, top all-ones
        run_ticks(4, 0, 255, 1'b1, 1'b1);

        repeat (4) @(negedge clock_in);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
